// File: rtl/sram_1rw1r_sync.sv
// Parametrised 1RW/1R synchronous SRAM with byte-lane masking, selectable read
// latency, port-1 write bypass on collisions and a post-reset zero-fill engine.
module sram_1rw1r_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int NUM_WMASKS     = DATA_WIDTH / BYTE_WIDTH,
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  collision,
    output logic [15:0]           collision_count
);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = old_w[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic                  init_busy_q;
    logic                  s1_vld0_q, s1_vld1_q;
    logic [DATA_WIDTH-1:0] s1_dout0_q, s1_dout1_q;
    logic                  s2_vld0_q, s2_vld1_q;
    logic [DATA_WIDTH-1:0] s2_dout0_q, s2_dout1_q;
    logic                  collision_q;
    logic [15:0]           coll_cnt_q;

    logic                  ready_s, rd0_s, wr0_s, rd1_s, in0_s, in1_s, collide_s;
    logic [DATA_WIDTH-1:0] old0_s, old1_s, rd1_data_d;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic [NUM_WMASKS-1:0] mem_wmask_s;

    // Request decode, collision detection and port-1 read data selection.
    always_comb begin
        ready_s   = (state_q == ST_READY);
        rd0_s     = ready_s && !csb0 && web0;
        wr0_s     = ready_s && !csb0 && !web0;
        rd1_s     = ready_s && !csb1;
        in0_s     = ({1'b0, addr0} < DEPTH_W);
        in1_s     = ({1'b0, addr1} < DEPTH_W);
        old0_s    = in0_s ? mem_q[addr0] : {DATA_WIDTH{1'b0}};
        old1_s    = in1_s ? mem_q[addr1] : {DATA_WIDTH{1'b0}};
        // Only a write that actually lands in the array can collide.
        collide_s = wr0_s && rd1_s && in0_s && (addr0 == addr1) && (wmask0 != {NUM_WMASKS{1'b0}});
        if (collide_s && (BYPASS != 0)) begin
            rd1_data_d = lane_merge(old1_s, din0, wmask0);
        end else begin
            rd1_data_d = old1_s;
        end
    end

    // Single array write port shared by the zero-fill engine and port 0.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_WIDTH{1'b0}};
        mem_wdata_s = {DATA_WIDTH{1'b0}};
        mem_wmask_s = {NUM_WMASKS{1'b0}};
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_q;
            mem_wmask_s = {NUM_WMASKS{1'b1}};
        end else if (wr0_s && in0_s) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = addr0;
            mem_wdata_s = din0;
            mem_wmask_s = wmask0;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // Storage array: byte-lane masked writes, intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mem_we_s && mem_wmask_s[i]) begin
                mem_q[mem_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Zero-fill FSM: walks every address once, then parks in READY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q  <= {ADDR_WIDTH{1'b0}};
            init_busy_q <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_q     <= ST_READY;
                        init_busy_q <= 1'b0;
                    end else begin
                        clr_addr_q  <= clr_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_READY: begin
                    init_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= ST_READY;
                    init_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Read pipelines and collision reporting; data registers hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld0_q   <= 1'b0;
            s1_vld1_q   <= 1'b0;
            s1_dout0_q  <= {DATA_WIDTH{1'b0}};
            s1_dout1_q  <= {DATA_WIDTH{1'b0}};
            s2_vld0_q   <= 1'b0;
            s2_vld1_q   <= 1'b0;
            s2_dout0_q  <= {DATA_WIDTH{1'b0}};
            s2_dout1_q  <= {DATA_WIDTH{1'b0}};
            collision_q <= 1'b0;
            coll_cnt_q  <= 16'h0000;
        end else begin
            s1_vld0_q   <= rd0_s;
            s1_vld1_q   <= rd1_s;
            s2_vld0_q   <= s1_vld0_q;
            s2_vld1_q   <= s1_vld1_q;
            collision_q <= collide_s;
            if (rd0_s)     s1_dout0_q <= old0_s;      else s1_dout0_q <= s1_dout0_q;
            if (rd1_s)     s1_dout1_q <= rd1_data_d;  else s1_dout1_q <= s1_dout1_q;
            if (s1_vld0_q) s2_dout0_q <= s1_dout0_q;  else s2_dout0_q <= s2_dout0_q;
            if (s1_vld1_q) s2_dout1_q <= s1_dout1_q;  else s2_dout1_q <= s2_dout1_q;
            if (collide_s && (coll_cnt_q != 16'hFFFF)) begin
                coll_cnt_q <= coll_cnt_q + 16'd1;
            end else begin
                coll_cnt_q <= coll_cnt_q;
            end
        end
    end

    assign init_busy       = init_busy_q;
    assign dout0           = (READ_LATENCY == 2) ? s2_dout0_q : s1_dout0_q;
    assign dout0_valid     = (READ_LATENCY == 2) ? s2_vld0_q  : s1_vld0_q;
    assign dout1           = (READ_LATENCY == 2) ? s2_dout1_q : s1_dout1_q;
    assign dout1_valid     = (READ_LATENCY == 2) ? s2_vld1_q  : s1_vld1_q;
    assign collision       = collision_q;
    assign collision_count = coll_cnt_q;

endmodule

// File: tb/tb_sram_1rw1r_sync.sv
// Randomised self-checking bench for sram_1rw1r_sync (default parameters)
// against an array-based reference model of the memory and its outputs.
module tb_sram_1rw1r_sync;

    logic        clk, rst_n, init_busy;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [8:0]  addr0, addr1;
    logic [31:0] din0, dout0, dout1;
    logic        dout0_valid, dout1_valid, collision;
    logic [15:0] collision_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl [512];
    logic [31:0] exp_d0, exp_d1;
    int          exp_cnt;
    int          n_v0, n_v1;

    sram_1rw1r_sync dut (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .dout0_valid(dout0_valid),
        .csb1(csb1), .addr1(addr1), .dout1(dout1), .dout1_valid(dout1_valid),
        .collision(collision), .collision_count(collision_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 9'd0; din0 = 32'd0;
        csb1 = 1'b1; addr1 = 9'd0;
    endtask

    task automatic model_reset();
        exp_d0 = 32'd0; exp_d1 = 32'd0; exp_cnt = 0;
    endtask

    // One clock of traffic; the model predicts every output for the next cycle.
    task automatic step(input logic c0, input logic w0, input logic [3:0] m0,
                        input logic [8:0] a0, input logic [31:0] d0,
                        input logic c1, input logic [8:0] a1, input bit chk);
        logic [31:0] merged;
        bit coll, v0, v1;
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
        merged = mdl[a0];
        for (int i = 0; i < 4; i++) if (m0[i]) merged[i*8 +: 8] = d0[i*8 +: 8];
        coll = !c0 && !w0 && !c1 && (a0 == a1) && (m0 != 4'h0);
        v0 = !c0 && w0;
        v1 = !c1;
        if (v0) exp_d0 = mdl[a0];
        if (v1) exp_d1 = coll ? merged : mdl[a1];
        if (coll && exp_cnt < 32'hFFFF) exp_cnt++;
        if (!c0 && !w0) mdl[a0] = merged;
        @(posedge clk); #1;
        n_v0 += int'(dout0_valid);
        n_v1 += int'(dout1_valid);
        if (chk) begin
            check("v0", {31'd0, dout0_valid}, {31'd0, v0});
            check("d0", dout0, exp_d0);
            check("v1", {31'd0, dout1_valid}, {31'd0, v1});
            check("d1", dout1, exp_d1);
            check("coll", {31'd0, collision}, {31'd0, coll});
            check("cnt", {16'd0, collision_count}, exp_cnt);
            check("busy", {31'd0, init_busy}, 32'd0);
        end
    endtask

    // Counts busy edges after release while poking both ports with traffic.
    task automatic wait_clear(input string tag);
        int  n;
        bit  bad;
        n = 0; bad = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            if (k[0]) begin
                csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 9'd3; din0 = 32'hFFFFFFFF;
            end else begin
                csb0 = 1'b0; web0 = 1'b1; wmask0 = 4'h0; addr0 = 9'h1FF;
            end
            csb1 = 1'b0; addr1 = (k[0]) ? 9'd3 : 9'h1FF;
            @(posedge clk); #1;
            n++;
            if (dout0_valid || dout1_valid || collision) bad = 1'b1;
            if (!init_busy) break;
        end
        idle();
        check(tag, n, 32'd512);
        check("busy_novalid", {31'd0, bad}, 32'd0);
        for (int i = 0; i < 512; i++) mdl[i] = 32'd0;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        check("rst_busy", {31'd0, init_busy}, 32'd1);
        check("rst_outs", {dout0 | dout1}, 32'd0);
        check("rst_flags", {28'd0, dout0_valid, dout1_valid, collision, |collision_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear("busy_cycles");

        // Cleared words, including those poked during the fill.
        step(1'b0, 1'b1, 4'h0, 9'h1FF, 32'd0, 1'b0, 9'd3, 1'b1);
        check("clr_1ff", dout0, 32'd0);
        check("clr_3", dout1, 32'd0);

        // Byte-lane masked write.
        step(1'b0, 1'b0, 4'hF, 9'd5, 32'hAABBCCDD, 1'b1, 9'd0, 1'b1);
        step(1'b0, 1'b0, 4'h5, 9'd5, 32'h11223344, 1'b1, 9'd0, 1'b1);
        step(1'b0, 1'b1, 4'h0, 9'd5, 32'd0, 1'b1, 9'd0, 1'b1);
        check("wmask_read", dout0, 32'hAA22CC44);

        // Collision with bypass, then a zero-mask write that must not collide.
        step(1'b0, 1'b0, 4'h3, 9'd7, 32'hFFFFFFFF, 1'b0, 9'd7, 1'b1);
        check("bypass_d1", dout1, 32'h0000FFFF);
        check("coll_cnt1", {16'd0, collision_count}, 32'd1);
        step(1'b0, 1'b0, 4'h0, 9'd7, 32'h12345678, 1'b0, 9'd7, 1'b1);
        step(1'b0, 1'b1, 4'h0, 9'd5, 32'd0, 1'b0, 9'd5, 1'b1);
        check("same_addr_rd", dout1, dout0 == 32'hAA22CC44 ? 32'hAA22CC44 : 32'hDEADBEEF);

        // Streaming reads at full throughput on both ports.
        n_v0 = 0; n_v1 = 0;
        for (int a = 0; a < 16; a++) step(1'b0, 1'b1, 4'h0, 9'(a), 32'd0, 1'b0, 9'(15 - a), 1'b1);
        check("stream_v0", n_v0, 32'd16);
        check("stream_v1", n_v1, 32'd16);

        // Random traffic over a narrow address window to provoke collisions.
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                 9'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) == 0),
                 9'($urandom_range(0, 15)), 1'b1);
        end

        // Reset mid-read, then again mid-fill at address 100.
        step(1'b0, 1'b1, 4'h0, 9'd5, 32'd0, 1'b0, 9'd5, 1'b1);
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("mid_rd_v", {30'd0, dout0_valid, dout1_valid}, 32'd0);
        check("mid_rd_d", dout0 | dout1, 32'd0);
        check("mid_rd_cnt", {16'd0, collision_count}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("mid_clr_busy", {31'd0, init_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_clr_rst", {31'd0, init_busy}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear("busy_restart");
        step(1'b0, 1'b1, 4'h0, 9'd5, 32'd0, 1'b0, 9'd7, 1'b1);

        // Saturating collision counter.
        for (int k = 0; k < 32'hFFFE; k++) step(1'b0, 1'b0, 4'h1, 9'd9, 32'h5A5A5A5A, 1'b0, 9'd9, 1'b0);
        check("cnt_fffe", {16'd0, collision_count}, 32'h0000FFFE);
        step(1'b0, 1'b0, 4'h2, 9'd9, 32'hA5A5A5A5, 1'b0, 9'd9, 1'b1);
        step(1'b0, 1'b0, 4'h4, 9'd9, 32'hC3C3C3C3, 1'b0, 9'd9, 1'b1);
        check("cnt_sat", {16'd0, collision_count}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
